// File: rtl/cpu_pkg.sv
// rtl/cpu_pkg.sv - shared opcode classes, instruction field positions and register address width
package cpu_pkg;

   localparam int INST_W  = 16;
   localparam int REG_AW  = 4;
   localparam int OPC_W   = 4;

   // Instruction layout: [15:12] opcode, [11:8] rd, [7:4] rs1, [3:0] rs2/imm4
   localparam int OPC_LSB = 12;
   localparam int RD_LSB  = 8;
   localparam int RS1_LSB = 4;
   localparam int RS2_LSB = 0;

   localparam logic [OPC_W-1:0] OPC_NOP      = 4'h0;
   localparam logic [OPC_W-1:0] OPC_IMM_BASE = 4'h8;

   typedef enum logic [1:0] {
      CLS_NOP = 2'd0,
      CLS_REG = 2'd1,
      CLS_IMM = 2'd2
   } opc_class_e;

   // NOP writes nothing; the upper half of the opcode space takes imm4 instead of rs2
   function automatic opc_class_e opc_class(input logic [OPC_W-1:0] opc);
      if (opc == OPC_NOP) begin
         return CLS_NOP;
      end else if (opc >= OPC_IMM_BASE) begin
         return CLS_IMM;
      end else begin
         return CLS_REG;
      end
   endfunction

endpackage

// File: rtl/decode_scoreboard.sv
// rtl/decode_scoreboard.sv - per-register pending bits and hazard detect; DECODE_WB_BYPASS_EN lets a same-cycle write-back clear the hazard
module decode_scoreboard
   import cpu_pkg::*;
#(
   parameter int REG_AW = cpu_pkg::REG_AW
) (
   input  logic              clk,
   input  logic              reset,
   input  logic [REG_AW-1:0] i_rs1,
   input  logic [REG_AW-1:0] i_rs2,
   input  logic [REG_AW-1:0] i_rd,
   input  logic              i_use_rs2,
   input  logic              i_writes,
   input  logic              i_set_en,
   input  logic [REG_AW-1:0] i_set_add,
   input  logic              i_clr_en,
   input  logic [REG_AW-1:0] i_clr_add,
   output logic              o_hazard
);

   localparam int NREG = 1 << REG_AW;

   logic [NREG-1:0] pending_q;
   logic [NREG-1:0] pending_d;
   logic [NREG-1:0] set_mask;
   logic [NREG-1:0] clr_mask;
   logic [NREG-1:0] pending_eff;

   // One-hot masks for the issuing destination and the retiring write-back
   always_comb begin
      set_mask = '0;
      clr_mask = '0;
      if (i_set_en) begin
         set_mask[i_set_add] = 1'b1;
      end
      if (i_clr_en) begin
         clr_mask[i_clr_add] = 1'b1;
      end
   end

`ifdef DECODE_WB_BYPASS_EN
   // Register file writes on the falling edge, so a retiring register is already safe to read
   assign pending_eff = pending_q & ~clr_mask;
`else
   assign pending_eff = pending_q;
`endif

   // Set is applied after clear so a same-register collision leaves the bit pending
   assign pending_d = (pending_q & ~clr_mask) | set_mask;

   assign o_hazard = pending_eff[i_rs1]
                   | (i_use_rs2 & pending_eff[i_rs2])
                   | (i_writes  & pending_eff[i_rd]);

   // Pending-bit storage, cleared immediately by reset
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         pending_q <= '0;
      end else begin
         pending_q <= pending_d;
      end
   end

endmodule

// File: rtl/decode_issue.sv
// rtl/decode_issue.sv - in-order decode/issue stage with register scoreboard; optional DECODE_WB_BYPASS_EN
module decode_issue
   import cpu_pkg::*;
#(
   parameter int INST_W = cpu_pkg::INST_W,
   parameter int REG_AW = cpu_pkg::REG_AW
) (
   input  logic              clk,
   input  logic              reset,
   input  logic              i_inst_valid,
   input  logic [INST_W-1:0] i_inst,
   output logic              o_inst_ready,
   output logic [REG_AW-1:0] o_read_add1,
   output logic [REG_AW-1:0] o_read_add2,
   output logic              o_immediate,
   output logic              o_ex_valid,
   output logic [3:0]        o_ex_opcode,
   output logic [REG_AW-1:0] o_ex_rd,
   output logic              o_ex_wen,
   input  logic              i_ex_ready,
   input  logic              i_wb_en,
   input  logic [REG_AW-1:0] i_wb_add,
   output logic              o_stall
);

   // Decoded fields of the offered instruction
   logic [OPC_W-1:0]  dec_opc;
   logic [REG_AW-1:0] dec_rd;
   logic [REG_AW-1:0] dec_rs1;
   logic [REG_AW-1:0] dec_rs2;
   opc_class_e        dec_cls;
   logic              dec_imm;
   logic              dec_wen;

   assign dec_opc = i_inst[OPC_LSB +: OPC_W];
   assign dec_rd  = i_inst[RD_LSB  +: REG_AW];
   assign dec_rs1 = i_inst[RS1_LSB +: REG_AW];
   assign dec_rs2 = i_inst[RS2_LSB +: REG_AW];
   assign dec_cls = opc_class(dec_opc);
   assign dec_imm = (dec_cls == CLS_IMM);
   assign dec_wen = (dec_cls != CLS_NOP);

   // ID/EX register
   logic              ex_valid_q, ex_valid_d;
   logic [OPC_W-1:0]  ex_opc_q,   ex_opc_d;
   logic [REG_AW-1:0] ex_rd_q,    ex_rd_d;
   logic              ex_wen_q,   ex_wen_d;
   logic [REG_AW-1:0] ex_ra1_q,   ex_ra1_d;
   logic [REG_AW-1:0] ex_ra2_q,   ex_ra2_d;
   logic              ex_imm_q,   ex_imm_d;

   logic hazard;
   logic issue;

   assign o_stall      = i_inst_valid & hazard;
   assign o_inst_ready = ~hazard & (~ex_valid_q | i_ex_ready);
   assign issue        = i_inst_valid & o_inst_ready;

   decode_scoreboard #(
      .REG_AW (REG_AW)
   ) u_sb (
      .clk       (clk),
      .reset     (reset),
      .i_rs1     (dec_rs1),
      .i_rs2     (dec_rs2),
      .i_rd      (dec_rd),
      .i_use_rs2 (~dec_imm),
      .i_writes  (dec_wen),
      .i_set_en  (issue & dec_wen),
      .i_set_add (dec_rd),
      .i_clr_en  (i_wb_en),
      .i_clr_add (i_wb_add),
      .o_hazard  (hazard)
   );

   // Load on issue, drop valid when execute consumes without a replacement, otherwise hold
   always_comb begin
      ex_valid_d = ex_valid_q;
      ex_opc_d   = ex_opc_q;
      ex_rd_d    = ex_rd_q;
      ex_wen_d   = ex_wen_q;
      ex_ra1_d   = ex_ra1_q;
      ex_ra2_d   = ex_ra2_q;
      ex_imm_d   = ex_imm_q;
      if (issue) begin
         ex_valid_d = 1'b1;
         ex_opc_d   = dec_opc;
         ex_rd_d    = dec_rd;
         ex_wen_d   = dec_wen;
         ex_ra1_d   = dec_rs1;
         ex_ra2_d   = dec_rs2;
         ex_imm_d   = dec_imm;
      end else if (i_ex_ready) begin
         ex_valid_d = 1'b0;
      end
   end

   // ID/EX state; reset discards any in-flight instruction
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         ex_valid_q <= 1'b0;
         ex_opc_q   <= '0;
         ex_rd_q    <= '0;
         ex_wen_q   <= 1'b0;
         ex_ra1_q   <= '0;
         ex_ra2_q   <= '0;
         ex_imm_q   <= 1'b0;
      end else begin
         ex_valid_q <= ex_valid_d;
         ex_opc_q   <= ex_opc_d;
         ex_rd_q    <= ex_rd_d;
         ex_wen_q   <= ex_wen_d;
         ex_ra1_q   <= ex_ra1_d;
         ex_ra2_q   <= ex_ra2_d;
         ex_imm_q   <= ex_imm_d;
      end
   end

   // Read addresses come from ID/EX so register-file data lines up with o_ex_*
   assign o_ex_valid  = ex_valid_q;
   assign o_ex_opcode = ex_opc_q;
   assign o_ex_rd     = ex_rd_q;
   assign o_ex_wen    = ex_wen_q;
   assign o_read_add1 = ex_ra1_q;
   assign o_read_add2 = ex_ra2_q;
   assign o_immediate = ex_imm_q;

endmodule

// File: tb/tb_decode_issue.sv
// tb/tb_decode_issue.sv - scoreboard bench for decode_issue with directed vectors
`timescale 1ns/1ps
module tb_decode_issue;

   logic        clk = 1'b0;
   logic        reset = 1'b1;
   logic        i_inst_valid = 1'b0;
   logic [15:0] i_inst = '0;
   logic        o_inst_ready;
   logic [3:0]  o_read_add1;
   logic [3:0]  o_read_add2;
   logic        o_immediate;
   logic        o_ex_valid;
   logic [3:0]  o_ex_opcode;
   logic [3:0]  o_ex_rd;
   logic        o_ex_wen;
   logic        i_ex_ready = 1'b0;
   logic        i_wb_en = 1'b0;
   logic [3:0]  i_wb_add = '0;
   logic        o_stall;

   int tests = 0;
   int fails = 0;
   logic [17:0] exp_q[$];
   logic [15:0] pend;

`ifdef DECODE_WB_BYPASS_EN
   localparam int EXP_WAIT_032 = 2;
`else
   localparam int EXP_WAIT_032 = 3;
`endif

   decode_issue dut (
      .clk          (clk),
      .reset        (reset),
      .i_inst_valid (i_inst_valid),
      .i_inst       (i_inst),
      .o_inst_ready (o_inst_ready),
      .o_read_add1  (o_read_add1),
      .o_read_add2  (o_read_add2),
      .o_immediate  (o_immediate),
      .o_ex_valid   (o_ex_valid),
      .o_ex_opcode  (o_ex_opcode),
      .o_ex_rd      (o_ex_rd),
      .o_ex_wen     (o_ex_wen),
      .i_ex_ready   (i_ex_ready),
      .i_wb_en      (i_wb_en),
      .i_wb_add     (i_wb_add),
      .o_stall      (o_stall)
   );

   assign pend = dut.u_sb.pending_q;

   always #5 clk = ~clk;

   // {opcode, rd, wen, read_add1, read_add2, immediate}
   function automatic logic [17:0] exp_of(input logic [15:0] inst);
      return {inst[15:12], inst[11:8], (inst[15:12] != 4'h0), inst[7:4], inst[3:0], inst[15]};
   endfunction

   function automatic logic [17:0] ex_now();
      return {o_ex_opcode, o_ex_rd, o_ex_wen, o_read_add1, o_read_add2, o_immediate};
   endfunction

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
      tests++;
      if (act !== req) begin
         fails++;
         $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, req);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic wb_pulse(input logic [3:0] addr);
      i_wb_en  = 1'b1;
      i_wb_add = addr;
      tick();
      i_wb_en  = 1'b0;
   endtask

   // Offer inst until accepted; optionally pulse write-back on loop cycle wb_cyc
   task automatic offer(input logic [15:0] inst, input int wb_cyc, input logic [3:0] wb_addr,
                        input int max_cyc, output int waited);
      bit done;
      done = 1'b0;
      waited = 0;
      i_inst = inst;
      i_inst_valid = 1'b1;
      while (!done && waited <= max_cyc) begin
         i_wb_en  = (waited == wb_cyc);
         i_wb_add = wb_addr;
         @(negedge clk);
         if (o_inst_ready) begin
            #1;
            exp_q.push_back(exp_of(inst));
            done = 1'b1;
         end else begin
            check("offer_stall", o_stall, 1);
            waited++;
         end
         tick();
      end
      i_inst_valid = 1'b0;
      i_wb_en = 1'b0;
      if (!done) begin
         tests++;
         fails++;
         $display("FAIL offer_timeout: inst 0x%h not accepted, waited %0d cycles", inst, waited);
      end
   endtask

   // Monitor: every instruction handed to execute is compared with the scoreboard head
   initial begin
      forever begin
         @(negedge clk);
         if (reset && o_ex_valid && i_ex_ready) begin
            if (exp_q.size() == 0) begin
               tests++;
               fails++;
               $display("FAIL ex_unexpected: got 0x%0h, expected no instruction", ex_now());
            end else begin
               check("ex_out", ex_now(), exp_q.pop_front());
            end
         end
      end
   end

   initial begin
      #200000;
      $display("FAIL watchdog: got timeout, expected finish");
      $fatal(1, "watchdog");
   end

   initial begin
      int w;
      // Asynchronous reset before any clock edge
      #1 reset = 1'b0;
      #1;
      check("rst_ex_valid", o_ex_valid, 0);
      check("rst_ex_fields", ex_now(), 0);
      check("rst_pending", pend, 0);
      tick();
      reset = 1'b1;
      i_ex_ready = 1'b1;

      // Basic issue of 0x1123
      offer(16'h1123, -1, 4'd0, 4, w);
      check("r031_wait", w, 0);
      check("r031_valid", o_ex_valid, 1);
      check("r031_rd", o_ex_rd, 1);
      check("r031_ra", {o_read_add1, o_read_add2, o_immediate}, 9'b0010_0011_0);
      i_inst = 16'h2415;
      @(negedge clk);
      check("r031_pending", pend, 16'h0002);
      check("stall_needs_valid", o_stall, 0);
      check("ready_hazard_novalid", o_inst_ready, 0);
      tick();

      // RAW on r1 released by write-back
      offer(16'h2415, 2, 4'd1, 8, w);
      check("r032_wait", w, EXP_WAIT_032);
      @(negedge clk);
      check("r032_pending", pend, 16'h0010);
      tick();

      // Immediate ignores a pending register in the rs2 field
      offer(16'h1700, -1, 4'd0, 4, w);
      check("r033_setup_wait", w, 0);
      offer(16'h9207, -1, 4'd0, 4, w);
      check("r033_wait", w, 0);
      check("r033_imm", {o_immediate, o_read_add2}, 5'b1_0111);
      check("r033_pending", pend, 16'h0094);

      // Execute back-pressure holds ID/EX
      i_ex_ready = 1'b0;
      i_inst = 16'h1811;
      i_inst_valid = 1'b1;
      for (int k = 0; k < 3; k++) begin
         @(negedge clk);
         check("r034_ready", o_inst_ready, 0);
         check("r034_stall", o_stall, 0);
         check("r034_hold", {o_ex_valid, ex_now()}, {1'b1, 18'b1001_0010_1_0000_0111_1});
         tick();
      end
      i_ex_ready = 1'b1;
      @(negedge clk);
      check("r034_release", o_inst_ready, 1);
      #1 exp_q.push_back(exp_of(16'h1811));
      tick();
      i_inst_valid = 1'b0;
      check("r034_issued_rd", o_ex_rd, 8);

      // Set and clear on the same register: set wins
      offer(16'h1300, 0, 4'd3, 4, w);
      check("r035_wait", w, 0);
      @(negedge clk);
      check("r035_pending", pend, 16'h019C);
      tick();

      // Write-back to a non-pending register is harmless, then retire the rest
      wb_pulse(4'd5);
      check("wb_nonpending", pend, 16'h019C);
      wb_pulse(4'd3);
      wb_pulse(4'd4);
      wb_pulse(4'd7);
      wb_pulse(4'd8);
      check("wb_retire", pend, 16'h0004);

      // Invalid offers are ignored; NOP never sets pending
      i_inst = 16'h1FFF;
      tick();
      tick();
      check("novalid_ex", o_ex_valid, 0);
      check("novalid_pending", pend, 16'h0004);
      offer(16'h0000, -1, 4'd0, 4, w);
      check("nop_wait", w, 0);
      check("nop_pending", pend, 16'h0004);

      // Reset mid-operation
      tick();
      i_ex_ready = 1'b0;
      offer(16'h1100, -1, 4'd0, 4, w);
      check("r036_wait", w, 0);
      check("r036_pre", {o_ex_valid, pend}, {1'b1, 16'h0006});
      #1 reset = 1'b0;
      #1;
      check("r036_ex_valid", o_ex_valid, 0);
      check("r036_pending", pend, 0);
      check("r036_fields", ex_now(), 0);
      exp_q.delete();
      tick();
      reset = 1'b1;
      i_ex_ready = 1'b1;

      // Normal operation after reset
      offer(16'h1123, -1, 4'd0, 4, w);
      check("post_rst_wait", w, 0);
      @(negedge clk);
      check("post_rst_pending", pend, 16'h0002);

      for (int k = 0; k < 10 && exp_q.size() != 0; k++) begin
         @(negedge clk);
      end
      check("drain", exp_q.size(), 0);

      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

endmodule

// File: doc/decode_issue.md
DECODE_ISSUE -- requirements
Module: decode_issue

Interface
REQ-001 SHALL have parameter INST_W, default 16, instruction word width.
REQ-002 SHALL have parameter REG_AW, default 4, register address width (16 registers).
REQ-003 SHALL have port clk  input  1  clock, all state updates on rising edge.
REQ-004 SHALL have port reset  input  1  reset, asynchronous, active-low.
REQ-005 SHALL have port i_inst_valid  input  1  fetch offers an instruction.
REQ-006 SHALL have port i_inst  input  INST_W  instruction: [15:12] opcode, [11:8] rd, [7:4] rs1, [3:0] rs2/imm4.
REQ-007 SHALL have port o_inst_ready  output  1  decode accepts i_inst this cycle.
REQ-008 SHALL have port o_read_add1 and o_read_add2  output  REG_AW each  register-file read addresses, rs1 and rs2/imm4 of the issued instruction.
REQ-009 SHALL have port o_immediate  output  1  issued instruction uses imm4 in place of rs2.
REQ-010 SHALL have ports o_ex_valid (1), o_ex_opcode (4), o_ex_rd (REG_AW), o_ex_wen (1), all outputs  issued instruction to execute.
REQ-011 SHALL have port i_ex_ready  input  1  execute consumes the issued instruction.
REQ-012 SHALL have ports i_wb_en (1) and i_wb_add (REG_AW), both inputs  write-back retire, same signals that drive the register-file write.
REQ-013 SHALL have port o_stall  output  1  valid instruction held back by a hazard.

Function
REQ-014 Opcode 0x0 SHALL be NOP (o_ex_wen=0); opcodes 0x8-0xF SHALL be immediate (o_immediate=1); all other nonzero opcodes SHALL write rd.
REQ-015 A scoreboard SHALL hold one pending bit per register.
REQ-016 Hazard SHALL be: pending[rs1], or pending[rs2] when not immediate, or pending[rd] when the instruction writes.
REQ-017 o_stall SHALL equal i_inst_valid AND hazard; o_inst_ready SHALL equal NOT hazard AND (NOT o_ex_valid OR i_ex_ready).
REQ-018 Issue SHALL occur when i_inst_valid AND o_inst_ready; the ID/EX register loads on the next edge, giving 1-cycle latency.
REQ-019 Without issue, i_ex_ready=1 SHALL clear o_ex_valid; with i_ex_ready=0, all o_ex_* and o_read_add* SHALL hold.
REQ-020 o_read_add1/2 and o_immediate SHALL be driven from the ID/EX register so that register-file data aligns with o_ex_*.
REQ-021 Issue of a writing instruction SHALL set pending[rd]; i_wb_en SHALL clear pending[i_wb_add].
REQ-022 If a set and a clear hit the same register in one cycle, the set SHALL win.
REQ-023 i_wb_en on a non-pending register SHALL be ignored without error.
REQ-024 i_inst SHALL be ignored when i_inst_valid=0; a NOP SHALL never set pending bits.

Reset
REQ-025 On reset low, o_ex_valid, o_ex_opcode, o_ex_rd, o_ex_wen, o_read_add1/2, o_immediate and all pending bits SHALL be 0 immediately.
REQ-026 Reset mid-operation SHALL discard the in-flight instruction; no write-back is expected for it.

Configuration
REQ-027 With macro DECODE_WB_BYPASS_EN defined, a register cleared by i_wb_en in the current cycle SHALL be treated as not pending in the hazard check, because the register file writes on the negative edge.
REQ-028 Without DECODE_WB_BYPASS_EN, the hazard check SHALL use registered pending bits only, costing one extra stall cycle after write-back.

Structure
REQ-029 Opcode constants, instruction field positions and REG_AW SHALL reside in shared package cpu_pkg.
REQ-030 Pending-bit storage, set/clear priority and the bypass option SHALL be the sub-module decode_scoreboard.

Verification
REQ-031 Reset, then i_inst=0x1123 valid with i_ex_ready=1 -> next cycle o_ex_valid=1, o_ex_rd=1, o_read_add1=2, o_read_add2=3, o_immediate=0, pending[1]=1.
REQ-032 Issue 0x1123, then 0x2415 (rs1=1) -> o_stall=1 until i_wb_en with i_wb_add=1; issue occurs the same cycle with bypass, one cycle later without.
REQ-033 i_inst=0x9207 (immediate, rs2 field=7) while pending[7]=1 -> no stall, o_immediate=1, o_read_add2=7.
REQ-034 i_ex_ready=0 with o_ex_valid=1 -> o_inst_ready=0; all o_ex_* hold for 3 cycles; release i_ex_ready -> next instruction issues.
REQ-035 i_wb_en with i_wb_add=3 and issue of 0x1300 in the same cycle -> pending[3]=1 afterward.
REQ-036 Reset asserted while o_ex_valid=1 and pending=0x0006 -> o_ex_valid=0 and pending=0 without a clock edge.
